access_enable_packer: RTL and testbench

ACCESS_ENABLE_PACKER -- requirements
Module: access_enable_packer

---
 rtl/access_enable_packer.sv | 136 +++++++++++++
 tb/tb_access_enable_packer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_enable_packer.sv
// access_enable_packer: packs RATIO consecutive WIDTH-bit words from an upstream
// FIFO read port into one WIDTH*RATIO-bit word on a downstream FIFO write port.
// A flush request emits a partially filled word, zero-padded in the high slots.
// Ports:
//   clock, reset             - single clock, synchronous active-high reset
//   upstream_empty/_read_data/_read_enable      - upstream FIFO read side
//   flush                    - single-cycle request to emit a partial word
//   downstream_full/_write_enable/_write_data/_write_count - downstream FIFO write side
//   idle                     - accumulator empty, no flush pending, output register empty
module access_enable_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         upstream_empty,
    input  logic [WIDTH-1:0]             upstream_read_data,
    output logic                         upstream_read_enable,
    input  logic                         flush,
    input  logic                         downstream_full,
    output logic                         downstream_write_enable,
    output logic [WIDTH*RATIO-1:0]       downstream_write_data,
    output logic [$clog2(RATIO+1)-1:0]   downstream_write_count,
    output logic                         idle
);

    localparam int unsigned CW    = $clog2(RATIO + 1);
    localparam int unsigned NSLOT = RATIO - 1;
    localparam int unsigned OW    = WIDTH * RATIO;

    logic [WIDTH-1:0] slot_q [NSLOT];
    logic [WIDTH-1:0] slot_d [NSLOT];
    logic [CW-1:0]    fill_q, fill_d;
    logic             flush_pending_q, flush_pending_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;

    logic          out_free;
    logic          acc_last;
    logic          emit_partial;
    logic          rd_en;
    logic          wr_en;
    logic          load_full;
    logic [OW-1:0] full_data;
    logic [OW-1:0] partial_data;

    // Handshake decode; both enables are forced low while reset is asserted.
    always_comb begin
        out_free     = !out_valid_q || !downstream_full;
        acc_last     = (fill_q == CW'(NSLOT));
        emit_partial = out_free && (flush_pending_q || (flush && (fill_q != '0)));
        rd_en        = !reset && !upstream_empty && !flush && !flush_pending_q
                       && (!acc_last || out_free);
        wr_en        = !reset && out_valid_q && !downstream_full;
        load_full    = rd_en && acc_last;
    end

    // Candidate output words: full word takes the incoming word as its top slot,
    // partial word keeps only the filled slots and zeros the rest.
    always_comb begin
        full_data    = '0;
        partial_data = '0;
        for (int i = 0; i < int'(NSLOT); i++) begin
            full_data[i*WIDTH +: WIDTH] = slot_q[i];
            if (CW'(i) < fill_q) begin
                partial_data[i*WIDTH +: WIDTH] = slot_q[i];
            end
        end
        full_data[NSLOT*WIDTH +: WIDTH] = upstream_read_data;
    end

    // Next-state logic. Reads and partial emission are mutually exclusive because
    // a read requires no flush request and no pending flush.
    always_comb begin
        slot_d          = slot_q;
        fill_d          = fill_q;
        flush_pending_d = flush_pending_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_count_d     = out_count_q;

        if (wr_en) begin
            out_valid_d = 1'b0;
        end

        if (load_full) begin
            out_data_d  = full_data;
            out_count_d = CW'(RATIO);
            out_valid_d = 1'b1;
            fill_d      = '0;
        end else if (rd_en) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                if (CW'(i) == fill_q) begin
                    slot_d[i] = upstream_read_data;
                end
            end
            fill_d = fill_q + CW'(1);
        end else if (emit_partial) begin
            out_data_d      = partial_data;
            out_count_d     = fill_q;
            out_valid_d     = 1'b1;
            fill_d          = '0;
            flush_pending_d = 1'b0;
        end else if (flush && (fill_q != '0)) begin
            // Output register busy: hold the partial word until it frees up.
            flush_pending_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q          <= '{default: '0};
            fill_q          <= '0;
            flush_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_count_q     <= '0;
        end else begin
            slot_q          <= slot_d;
            fill_q          <= fill_d;
            flush_pending_q <= flush_pending_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_count_q     <= out_count_d;
        end
    end

    assign upstream_read_enable    = rd_en;
    assign downstream_write_enable = wr_en;
    assign downstream_write_data   = out_data_q;
    assign downstream_write_count  = out_count_q;
    assign idle                    = (fill_q == '0) && !flush_pending_q && !out_valid_q;

endmodule

// File: tb/tb_access_enable_packer.sv
// tb_access_enable_packer: scoreboard bench for access_enable_packer (WIDTH=8, RATIO=4).
// Accepted upstream words feed a packing model; expected packed words are queued
// and popped as the DUT writes downstream.
module tb_access_enable_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned OW    = WIDTH * RATIO;
    localparam int unsigned CW    = $clog2(RATIO + 1);

    typedef struct packed {
        logic [OW-1:0] data;
        logic [CW-1:0] count;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             upstream_empty;
    logic [WIDTH-1:0] upstream_read_data;
    logic             upstream_read_enable;
    logic             flush;
    logic             downstream_full;
    logic             downstream_write_enable;
    logic [OW-1:0]    downstream_write_data;
    logic [CW-1:0]    downstream_write_count;
    logic             idle;

    access_enable_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .upstream_empty         (upstream_empty),
        .upstream_read_data     (upstream_read_data),
        .upstream_read_enable   (upstream_read_enable),
        .flush                  (flush),
        .downstream_full        (downstream_full),
        .downstream_write_enable(downstream_write_enable),
        .downstream_write_data  (downstream_write_data),
        .downstream_write_count (downstream_write_count),
        .idle                   (idle)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] src_q [$];
    logic [WIDTH-1:0] acc   [$];
    exp_t             sb    [$];
    int               checks;
    int               errors;
    int               rd_total;
    int               wr_total;
    logic             last_rd;
    logic             last_wr;

    task automatic refresh();
        upstream_empty     = (src_q.size() == 0);
        upstream_read_data = (src_q.size() == 0) ? '0 : src_q[0];
    endtask

    task automatic feed(input logic [WIDTH-1:0] w);
        src_q.push_back(w);
        refresh();
    endtask

    // One clock cycle: sample at negedge, update model/scoreboard, advance past posedge.
    task automatic tick();
        logic          rd;
        logic          wr;
        exp_t          e;
        logic [OW-1:0] pdata;
        @(negedge clock);
        rd = upstream_read_enable;
        wr = downstream_write_enable;
        if (flush && acc.size() > 0) begin
            pdata = '0;
            foreach (acc[i]) pdata[i*WIDTH +: WIDTH] = acc[i];
            e.data  = pdata;
            e.count = CW'(acc.size());
            sb.push_back(e);
            acc.delete();
        end
        if (rd) begin
            checks++;
            if (upstream_empty !== 1'b0) begin
                errors++;
                $display("FAIL read_while_empty: upstream_empty=%b required 0", upstream_empty);
            end
            acc.push_back(upstream_read_data);
            rd_total++;
            if (acc.size() == RATIO) begin
                pdata = '0;
                foreach (acc[i]) pdata[i*WIDTH +: WIDTH] = acc[i];
                e.data  = pdata;
                e.count = CW'(RATIO);
                sb.push_back(e);
                acc.delete();
            end
        end
        if (wr) begin
            wr_total++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: data=%h count=%0d required no write",
                         downstream_write_data, downstream_write_count);
            end else begin
                e = sb.pop_front();
                if (downstream_write_data !== e.data || downstream_write_count !== e.count) begin
                    errors++;
                    $display("FAIL write_payload: data=%h count=%0d required data=%h count=%0d",
                             downstream_write_data, downstream_write_count, e.data, e.count);
                end
            end
        end
        last_rd = rd;
        last_wr = wr;
        @(posedge clock);
        #1;
        if (rd && src_q.size() > 0) void'(src_q.pop_front());
        flush = 1'b0;
        refresh();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || sb.size() > 0 || idle !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: pending_src=%0d pending_exp=%0d idle=%b required all drained",
                     src_q.size(), sb.size(), idle);
        end
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        flush              = 1'b0;
        downstream_full    = 1'b0;
        upstream_empty     = 1'b0;
        upstream_read_data = 8'h5A;
        #1;
        checks++;
        if (upstream_read_enable !== 1'b0 || downstream_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_enables: rd=%b wr=%b required 0 0",
                     upstream_read_enable, downstream_write_enable);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (downstream_write_data !== '0 || downstream_write_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h count=%0d required 0 0",
                     downstream_write_data, downstream_write_count);
        end
        reset = 1'b0;
        refresh();
        #1;
        checks++;
        if (idle !== 1'b1 || upstream_read_enable !== 1'b0 || downstream_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: idle=%b rd=%b wr=%b required 1 0 0",
                     idle, upstream_read_enable, downstream_write_enable);
        end
    endtask

    task automatic test_basic();
        int r0, w0, c4, cw;
        r0 = rd_total; w0 = wr_total; c4 = -1; cw = -1;
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_rd && (rd_total - r0) == 4 && c4 < 0) c4 = k;
            if (last_wr && cw < 0) cw = k;
        end
        checks++;
        if (c4 != 3) begin
            errors++;
            $display("FAIL basic_reads: fourth read at cycle %0d required 3", c4);
        end
        checks++;
        if (cw != 4) begin
            errors++;
            $display("FAIL basic_latency: write at cycle %0d required 4", cw);
        end
        checks++;
        if ((wr_total - w0) != 1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL basic_writes: writes=%0d idle=%b required 1 1", wr_total - w0, idle);
        end
    endtask

    task automatic test_stream();
        int n, w0;
        n = 0; w0 = wr_total;
        for (int k = 0; k < 16; k++) feed(8'(k));
        for (int k = 0; k < 16; k++) begin
            tick();
            if (last_rd) n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL stream_reads: %0d read cycles required 16", n);
        end
        drain(20);
        checks++;
        if ((wr_total - w0) != 4) begin
            errors++;
            $display("FAIL stream_writes: %0d required 4", wr_total - w0);
        end
    endtask

    task automatic test_backpressure();
        int r0, w0;
        w0 = wr_total;
        for (int k = 0; k < 8; k++) feed(8'(8'h20 + k));
        repeat (4) tick();
        downstream_full = 1'b1;
        r0 = rd_total;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (downstream_write_data !== 32'h23222120) begin
                errors++;
                $display("FAIL bp_hold: data=%h required 23222120", downstream_write_data);
            end
        end
        checks++;
        if ((rd_total - r0) != 3 || upstream_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL bp_reads: reads=%0d rd=%b required 3 0", rd_total - r0, upstream_read_enable);
        end
        checks++;
        if (wr_total != w0) begin
            errors++;
            $display("FAIL bp_no_write: writes=%0d required 0", wr_total - w0);
        end
        downstream_full = 1'b0;
        drain(20);
        checks++;
        if ((wr_total - w0) != 2) begin
            errors++;
            $display("FAIL bp_writes: %0d required 2", wr_total - w0);
        end
    endtask

    task automatic test_flush();
        int w0;
        feed(8'hAA); feed(8'hBB);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        tick();
        checks++;
        if (last_wr !== 1'b1) begin
            errors++;
            $display("FAIL flush_write_timing: wr=%b required 1", last_wr);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: idle=%b required 1", idle);
        end
        w0 = wr_total;
        flush = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (wr_total != w0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: writes=%0d idle=%b required 0 1", wr_total - w0, idle);
        end
    endtask

    task automatic test_flush_blocked();
        int r0, w0;
        w0 = wr_total;
        for (int k = 0; k < 8; k++) feed(8'(8'h30 + k));
        repeat (4) tick();
        downstream_full = 1'b1;
        repeat (2) tick();
        r0 = rd_total;
        flush = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (rd_total != r0 || wr_total != w0) begin
            errors++;
            $display("FAIL fb_blocked: reads=%0d writes=%0d required 0 0", rd_total - r0, wr_total - w0);
        end
        downstream_full = 1'b0;
        tick();
        checks++;
        if (last_wr !== 1'b1 || last_rd !== 1'b0) begin
            errors++;
            $display("FAIL fb_full_drain: wr=%b rd=%b required 1 0", last_wr, last_rd);
        end
        tick();
        checks++;
        if (last_wr !== 1'b1) begin
            errors++;
            $display("FAIL fb_partial_timing: wr=%b required 1", last_wr);
        end
        for (int k = 0; k < 5; k++) if (src_q.size() > 0) tick();
        flush = 1'b1;
        tick();
        drain(20);
        checks++;
        if ((wr_total - w0) != 3) begin
            errors++;
            $display("FAIL fb_writes: %0d required 3", wr_total - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        for (int k = 0; k < 4; k++) feed(8'(8'h40 + k));
        repeat (4) tick();
        downstream_full = 1'b1;
        feed(8'h44); feed(8'h45);
        repeat (2) tick();
        checks++;
        if (downstream_write_data !== 32'h43424140 || idle !== 1'b0) begin
            errors++;
            $display("FAIL rm_before: data=%h idle=%b required 43424140 0", downstream_write_data, idle);
        end
        reset = 1'b1;
        downstream_full = 1'b0;
        src_q.delete();
        upstream_empty = 1'b0;
        upstream_read_data = 8'h99;
        #1;
        checks++;
        if (upstream_read_enable !== 1'b0 || downstream_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL rm_enables: rd=%b wr=%b required 0 0", upstream_read_enable, downstream_write_enable);
        end
        @(posedge clock); #1;
        checks++;
        if (downstream_write_data !== '0 || downstream_write_count !== '0 || downstream_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL rm_outputs: data=%h count=%0d wr=%b required 0 0 0",
                     downstream_write_data, downstream_write_count, downstream_write_enable);
        end
        reset = 1'b0;
        refresh();
        acc.delete();
        sb.delete();
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL rm_idle: idle=%b required 1", idle);
        end
        w0 = wr_total;
        for (int k = 0; k < 4; k++) feed(8'(8'h50 + k));
        drain(20);
        checks++;
        if ((wr_total - w0) != 1) begin
            errors++;
            $display("FAIL rm_writes: %0d required 1", wr_total - w0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; rd_total = 0; wr_total = 0;
        last_rd = 1'b0; last_wr = 1'b0;
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_blocked();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
